// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the alu_muldiv execute unit
package alu_pkg;
   localparam logic [1:0] FS_ALU = 2'b00, FS_BR = 2'b01, FS_MD = 2'b10;
   localparam logic [2:0] F3_ADD = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR = 3'b100, F3_SR = 3'b101, F3_OR = 3'b110, F3_AND = 3'b111;
   localparam logic [2:0] F3_BEQ = 3'b000, F3_BNE = 3'b001, F3_BLT = 3'b100;
   localparam logic [2:0] F3_BGE = 3'b101, F3_BLTU = 3'b110, F3_BGEU = 3'b111;
   localparam logic [2:0] F3_MULHU = 3'b011;
   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: unsigned shift-add multiplier / restoring divider, BITS_PER_CYCLE bits per step.
// Accumulator ends as {hi, lo} product or {remainder, quotient}.
module muldiv_iter #(
   parameter int XLEN = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic              i_step,
   input  logic              i_div,
   input  logic [XLEN-1:0]   i_a,
   input  logic [XLEN-1:0]   i_b,
   output logic              o_last,
   output logic [2*XLEN-1:0] o_acc
);
   localparam int CW = $clog2(XLEN / BITS_PER_CYCLE + 1);
   logic [2*XLEN-1:0] r_acc, w_nxt;
   logic [XLEN-1:0]   r_op;
   logic [CW-1:0]     r_cnt;
   logic              r_div, w_ge;
   logic [XLEN:0]     w_t;
   always_comb begin
      w_nxt = r_acc;
      w_t   = '0;
      w_ge  = 1'b0;
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
         if (r_div) begin
            w_t   = {w_nxt[2*XLEN-1:XLEN], w_nxt[XLEN-1]};
            w_ge  = w_t >= {1'b0, r_op};
            w_t   = w_ge ? w_t - {1'b0, r_op} : w_t;
            w_nxt = {w_t[XLEN-1:0], w_nxt[XLEN-2:0], w_ge};
         end else begin
            w_t   = {1'b0, w_nxt[2*XLEN-1:XLEN]} + (w_nxt[0] ? {1'b0, r_op} : '0);
            w_nxt = {w_t, w_nxt[XLEN-1:1]};
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_op  <= '0;
         r_cnt <= '0;
         r_div <= 1'b0;
      end else if (i_start) begin
         r_acc <= {{XLEN{1'b0}}, i_a};
         r_op  <= i_b;
         r_div <= i_div;
         r_cnt <= CW'(XLEN / BITS_PER_CYCLE);
      end else if (i_step) begin
         r_acc <= w_nxt;
         r_cnt <= r_cnt - 1'b1;
      end
   end
   assign o_last = r_cnt == CW'(1);
   assign o_acc  = r_acc;
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: RV32I ALU and branch comparator plus iterative RV32M engine behind valid/ready.
// Operands enter the iterator as magnitudes; sign is restored in FIX.
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      func_sel,
   input  logic [2:0]      funct3,
   input  logic            alt_bit,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            branch_taken,
   output logic            busy
);
   localparam int SW = $clog2(XLEN);
   state_t            r_state, w_next;
   logic [XLEN-1:0]   r_result, w_alu, w_am, w_bm, w_spec, w_fix, w_lo, w_hi;
   logic [2*XLEN-1:0] w_acc, w_prod;
   logic [2:0]        r_f3;
   logic              r_taken, r_neg, w_accept, w_md, w_div, w_a_s, w_b_s, w_neg;
   logic              w_dz, w_ovf, w_special, w_br, w_last;
   logic [SW-1:0]     w_sh;
   assign w_sh      = b[SW-1:0];
   assign w_md      = func_sel == FS_MD;
   assign w_div     = funct3[2];
   assign w_a_s     = a[XLEN-1] & (w_div ? ~funct3[0] : funct3 != F3_MULHU);
   assign w_b_s     = b[XLEN-1] & (w_div ? ~funct3[0] : ~funct3[1]);
   assign w_neg     = (w_div & funct3[1]) ? w_a_s : w_a_s ^ w_b_s;
   assign w_am      = w_a_s ? -a : a;
   assign w_bm      = w_b_s ? -b : b;
   assign w_dz      = w_div && b == '0;
   assign w_ovf     = w_div && !funct3[0] && a == {1'b1, {(XLEN-1){1'b0}}} && &b;
   assign w_special = w_dz | w_ovf;
   assign w_spec    = w_dz ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);
   assign w_accept  = in_valid & in_ready;
   always_comb begin
      case (funct3)
         F3_ADD:  w_alu = alt_bit ? a - b : a + b;
         F3_SLL:  w_alu = a << w_sh;
         F3_SLT:  w_alu = XLEN'($signed(a) < $signed(b));
         F3_SLTU: w_alu = XLEN'(a < b);
         F3_XOR:  w_alu = a ^ b;
         F3_SR:   w_alu = alt_bit ? $unsigned($signed(a) >>> w_sh) : a >> w_sh;
         F3_OR:   w_alu = a | b;
         default: w_alu = a & b;
      endcase
   end
   always_comb begin
      case (funct3)
         F3_BEQ:  w_br = a == b;
         F3_BNE:  w_br = a != b;
         F3_BLT:  w_br = $signed(a) < $signed(b);
         F3_BGE:  w_br = $signed(a) >= $signed(b);
         F3_BLTU: w_br = a < b;
         F3_BGEU: w_br = a >= b;
         default: w_br = 1'b0;
      endcase
   end
   muldiv_iter #(.XLEN(XLEN), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_iter (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_accept & w_md & ~w_special),
      .i_step  (r_state == S_MUL || r_state == S_DIV),
      .i_div   (w_div),
      .i_a     (w_am),
      .i_b     (w_bm),
      .o_last  (w_last),
      .o_acc   (w_acc)
   );
   // Product sign applies to the full 2*XLEN word; quotient and remainder are fixed separately.
   assign w_prod = r_neg ? -w_acc : w_acc;
   assign w_lo   = r_neg ? -w_acc[XLEN-1:0] : w_acc[XLEN-1:0];
   assign w_hi   = r_neg ? -w_acc[2*XLEN-1:XLEN] : w_acc[2*XLEN-1:XLEN];
   assign w_fix  = r_f3[2] ? (r_f3[1] ? w_hi : w_lo)
                           : (r_f3[1:0] == 2'b00 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      if (w_accept)                                      w_next = (w_md && !w_special) ? (w_div ? S_DIV : S_MUL) : S_DONE;
      else if (r_state == S_DONE && out_ready)           w_next = S_IDLE;
      else if ((r_state == S_MUL || r_state == S_DIV) && w_last) w_next = S_FIX;
      else if (r_state == S_FIX)                         w_next = S_DONE;
      if (flush) w_next = S_IDLE;
   end
   always_comb begin
      out_valid = r_state == S_DONE;
      busy      = r_state == S_MUL || r_state == S_DIV || r_state == S_FIX;
      in_ready  = (r_state == S_IDLE || (out_valid && out_ready)) && rst_n && !flush;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_result <= '0;
         r_taken  <= 1'b0;
         r_neg    <= 1'b0;
         r_f3     <= '0;
      end else if (w_accept) begin
         r_taken <= func_sel == FS_BR && w_br;
         r_neg   <= w_neg;
         r_f3    <= funct3;
         if (!w_md)          r_result <= func_sel == FS_BR ? '0 : w_alu;
         else if (w_special) r_result <= w_spec;
      end else if (r_state == S_FIX && !flush) begin
         r_result <= w_fix;
      end
   end
   assign result       = r_result;
   assign branch_taken = r_taken;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors on two instances (1 and 4 bits per cycle) with a
// cycle-accurate reference model checked on every falling edge.
module tb_alu_muldiv;
   logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1, alt_bit = 1'b0;
   logic [1:0]  func_sel = '0;
   logic [2:0]  funct3 = '0;
   logic [31:0] a = '0, b = '0;
   logic        ov[2], ir[2], bt[2], bz[2];
   logic [31:0] res[2];
   int          total = 0, bad = 0, cyc = 0;
   bit          rst_q = 1'b0;
   bit          pv[2], pt[2], piter[2];
   logic [31:0] pr[2];
   int          pdue[2];
   logic        m_ev, m_eir, m_t;
   logic [31:0] m_r;
   int          m_l;

   always #5 clk = ~clk;

   alu_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) u0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
      .func_sel(func_sel), .funct3(funct3), .alt_bit(alt_bit), .a(a), .b(b),
      .out_valid(ov[0]), .out_ready(out_ready), .result(res[0]), .branch_taken(bt[0]), .busy(bz[0]));
   alu_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4)) u1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
      .func_sel(func_sel), .funct3(funct3), .alt_bit(alt_bit), .a(a), .b(b),
      .out_valid(ov[1]), .out_ready(out_ready), .result(res[1]), .branch_taken(bt[1]), .busy(bz[1]));

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%h want=%h t=%0t", nm, d, act, exp, $time);
      end
   endtask

   // RISC-V semantics from plain 64-bit arithmetic; latency from the operation class.
   function automatic void model(input logic [1:0] fs, input logic [2:0] f3, input logic alt,
                                 input logic [31:0] x, input logic [31:0] y, input int bpc,
                                 output logic [31:0] r, output logic t, output int lat);
      longint sx = longint'($signed(x)), sy = longint'($signed(y));
      longint ux = longint'({32'd0, x}), uy = longint'({32'd0, y});
      logic [63:0] p;
      r = '0; t = 1'b0; lat = 1; p = '0;
      if (fs == 2'b01) begin
         case (f3)
            3'd0: t = x == y;
            3'd1: t = x != y;
            3'd4: t = sx < sy;
            3'd5: t = sx >= sy;
            3'd6: t = x < y;
            3'd7: t = x >= y;
            default: t = 1'b0;
         endcase
      end else if (fs == 2'b10) begin
         if (!f3[2]) begin
            lat = 32 / bpc + 2;
            case (f3[1:0])
               2'd0, 2'd1: p = 64'(sx * sy);
               2'd2:       p = 64'(sx * uy);
               default:    p = 64'(ux * uy);
            endcase
            r = f3[1:0] == 2'd0 ? p[31:0] : p[63:32];
         end else if (y == 0) r = f3[1] ? x : 32'hFFFF_FFFF;
         else if (!f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = f3[1] ? 32'd0 : x;
         else begin
            lat = 32 / bpc + 2;
            if (!f3[0]) r = f3[1] ? 32'(sx % sy) : 32'(sx / sy);
            else        r = f3[1] ? 32'(ux % uy) : 32'(ux / uy);
         end
      end else begin
         case (f3)
            3'd0: r = alt ? x - y : x + y;
            3'd1: r = x << y[4:0];
            3'd2: r = {31'd0, sx < sy};
            3'd3: r = {31'd0, x < y};
            3'd4: r = x ^ y;
            3'd5: r = alt ? 32'(sx >>> y[4:0]) : x >> y[4:0];
            3'd6: r = x | y;
            default: r = x & y;
         endcase
      end
   endfunction

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst_n;
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            chk("rst_in_ready", d, {31'd0, ir[d]}, 32'd0);
            if (!rst_q) begin
               chk("rst_out_valid", d, {31'd0, ov[d]}, 32'd0);
               chk("rst_result", d, res[d], 32'd0);
               chk("rst_taken", d, {31'd0, bt[d]}, 32'd0);
               chk("rst_busy", d, {31'd0, bz[d]}, 32'd0);
            end
            pv[d] <= 1'b0;
         end else begin
            m_ev  = pv[d] && cyc >= pdue[d];
            m_eir = (!pv[d] || (m_ev && out_ready)) && !flush;
            chk("out_valid", d, {31'd0, ov[d]}, {31'd0, m_ev});
            chk("in_ready", d, {31'd0, ir[d]}, {31'd0, m_eir});
            chk("busy", d, {31'd0, bz[d]}, {31'd0, pv[d] && piter[d] && !m_ev});
            if (m_ev) begin
               chk("result", d, res[d], pr[d]);
               chk("taken", d, {31'd0, bt[d]}, {31'd0, pt[d]});
            end
            if (flush) pv[d] <= 1'b0;
            else if (in_valid && m_eir) begin
               model(func_sel, funct3, alt_bit, a, b, d == 0 ? 1 : 4, m_r, m_t, m_l);
               pv[d]    <= 1'b1;
               pr[d]    <= m_r;
               pt[d]    <= m_t;
               pdue[d]  <= cyc + m_l;
               piter[d] <= m_l > 1;
            end else if (m_ev && out_ready) pv[d] <= 1'b0;
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((pv[0] || pv[1]) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("idle_wait", 0, {31'd0, n < 200}, 32'd1);
   endtask

   task automatic drive(input logic [1:0] fs, input logic [2:0] f3, input logic alt,
                        input logic [31:0] x, input logic [31:0] y);
      func_sel = fs; funct3 = f3; alt_bit = alt; a = x; b = y;
   endtask

   task automatic run_op(input string nm, input logic [1:0] fs, input logic [2:0] f3, input logic alt,
                         input logic [31:0] x, input logic [31:0] y, input logic [31:0] er,
                         input logic et, input int l0, input int l1);
      bit g0 = 1'b0, g1 = 1'b0;
      wait_idle();
      @(posedge clk); #1;
      drive(fs, f3, alt, x, y);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int n = 1; n <= 60 && !(g0 && g1); n++) begin
         @(negedge clk);
         if (!g0 && ov[0]) begin
            g0 = 1'b1;
            chk(nm, 0, res[0], er);
            chk({nm, "_taken"}, 0, {31'd0, bt[0]}, {31'd0, et});
            chk({nm, "_lat"}, 0, n, l0);
         end
         if (!g1 && ov[1]) begin
            g1 = 1'b1;
            chk(nm, 1, res[1], er);
            chk({nm, "_lat"}, 1, n, l1);
         end
      end
      chk({nm, "_seen"}, 0, {31'd0, g0}, 32'd1);
      chk({nm, "_seen"}, 1, {31'd0, g1}, 32'd1);
   endtask

   task automatic abort_div(input bit use_reset, input int wait_cycles);
      bit stray = 1'b0;
      wait_idle();
      @(posedge clk); #1;
      drive(2'b10, 3'b100, 1'b0, 32'd100, 32'd7);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (wait_cycles) @(posedge clk);
      #1;
      if (use_reset) rst_n = 1'b0; else flush = 1'b1;
      @(posedge clk); #1;
      chk(use_reset ? "rst_abort_busy" : "flush_busy", 0, {31'd0, bz[0]}, 32'd0);
      chk(use_reset ? "rst_abort_valid" : "flush_valid", 0, {31'd0, ov[0]}, 32'd0);
      if (use_reset) begin
         @(posedge clk); #1;
         chk("rst_abort_result", 0, res[0], 32'd0);
      end
      rst_n = 1'b1; flush = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (ov[0]) stray = 1'b1;
      end
      chk("abort_no_valid", 0, {31'd0, stray}, 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("reset_result", d, res[d], 32'd0);
         chk("reset_valid", d, {31'd0, ov[d]}, 32'd0);
         chk("reset_ready", d, {31'd0, ir[d]}, 32'd0);
      end
      rst_n = 1'b1;
      // ALU
      run_op("sra", 2'b00, 3'b101, 1'b1, 32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFFF, 1'b0, 1, 1);
      run_op("srl", 2'b00, 3'b101, 1'b0, 32'hFFFF_FFF0, 32'd4, 32'h0FFF_FFFF, 1'b0, 1, 1);
      run_op("sub", 2'b00, 3'b000, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1, 1);
      run_op("add_ovf", 2'b00, 3'b000, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1, 1);
      run_op("sll31", 2'b00, 3'b001, 1'b0, 32'd1, 32'h0000_003F, 32'h8000_0000, 1'b0, 1, 1);
      run_op("slt", 2'b00, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 1);
      run_op("sltu", 2'b00, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, 1);
      run_op("xor", 2'b00, 3'b100, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1, 1);
      run_op("or", 2'b00, 3'b110, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1, 1);
      run_op("and", 2'b00, 3'b111, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1, 1);
      run_op("rsv_add", 2'b11, 3'b000, 1'b0, 32'd2, 32'd3, 32'd5, 1'b0, 1, 1);
      // Branch
      run_op("blt", 2'b01, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1, 1);
      run_op("bltu", 2'b01, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, 1);
      run_op("bgeu", 2'b01, 3'b111, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1, 1);
      run_op("b010", 2'b01, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, 1);
      run_op("beq", 2'b01, 3'b000, 1'b0, 32'd5, 32'd5, 32'd0, 1'b1, 1, 1);
      run_op("bge", 2'b01, 3'b101, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, 1);
      // Multiply
      run_op("mul", 2'b10, 3'b000, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0, 34, 10);
      run_op("mulh", 2'b10, 3'b001, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 1'b0, 34, 10);
      run_op("mulhsu", 2'b10, 3'b010, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 1'b0, 34, 10);
      run_op("mulhu", 2'b10, 3'b011, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 1'b0, 34, 10);
      // Divide
      run_op("div", 2'b10, 3'b100, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34, 10);
      run_op("rem", 2'b10, 3'b110, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 34, 10);
      run_op("divu", 2'b10, 3'b101, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b0, 34, 10);
      run_op("remu", 2'b10, 3'b111, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd1, 1'b0, 34, 10);
      run_op("divu0", 2'b10, 3'b101, 1'b0, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 1);
      run_op("rem0", 2'b10, 3'b110, 1'b0, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b0, 1, 1);
      run_op("div_ovf", 2'b10, 3'b100, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 1);
      run_op("rem_ovf", 2'b10, 3'b110, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 1);
      // Back-to-back ALU ops, one result per cycle
      wait_idle();
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         drive(2'b00, 3'b000, 1'b0, i, 32'd10);
         in_valid = 1'b1;
         @(posedge clk); #1;
         chk("b2b_valid", 0, {31'd0, ov[0]}, 32'd1);
         chk("b2b_result", 0, res[0], 32'(i + 10));
      end
      in_valid = 1'b0;
      // Backpressure
      wait_idle();
      @(posedge clk); #1;
      out_ready = 1'b0;
      drive(2'b00, 3'b000, 1'b0, 32'h11, 32'h22);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            chk("bp_valid", d, {31'd0, ov[d]}, 32'd1);
            chk("bp_result", d, res[d], 32'h33);
            chk("bp_in_ready", d, {31'd0, ir[d]}, 32'd0);
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release", 0, {31'd0, ov[0]}, 32'd0);
      // Aborts
      abort_div(1'b0, 9);
      run_op("post_flush", 2'b00, 3'b000, 1'b0, 32'd1, 32'd2, 32'd3, 1'b0, 1, 1);
      abort_div(1'b0, 5);
      abort_div(1'b1, 9);
      run_op("post_reset", 2'b00, 3'b100, 1'b0, 32'hFF, 32'h0F, 32'hF0, 1'b0, 1, 1);
      wait_idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised execute unit for the RV32I/RV32IM single-cycle-to-multicycle core migration. Combines the base integer ALU and branch comparator with an iterative RV32M multiply/divide engine behind a valid/ready handshake, so the core stalls only on M-extension operations. Sits between the decode/register-read stage and writeback; `branch_taken` feeds PC selection.

## Interface
- `XLEN`, 32: operand/result width.
- `BITS_PER_CYCLE`, 1: multiply/divide bits retired per iteration; must divide `XLEN` (1, 2, 4).
- `clk` input 1: clock, all state on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `flush` input 1: synchronous abort of any operation in flight.
- `in_valid` input 1: operation request.
- `in_ready` output 1: unit can accept this cycle.
- `func_sel` input 2: 00 ALU, 01 branch compare, 10 mul/div, 11 reserved (treated as ALU).
- `funct3` input 3: instruction funct3.
- `alt_bit` input 1: instr[30]; SUB vs ADD, SRA vs SRL.
- `a`, `b` input XLEN: rs1 and rs2/immediate operands.
- `out_valid` output 1: result valid, held until accepted.
- `out_ready` input 1: consumer accepts result.
- `result` output XLEN: registered result.
- `branch_taken` output 1: registered branch decision, valid with `out_valid`.
- `busy` output 1: state is MUL or DIV or FIX.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- `in_ready` = (IDLE or (DONE and `out_ready`)) and `rst_n` and not `flush`. Accept = `in_valid` and `in_ready`.
- ALU accept: compute and register `result`; go DONE. funct3 000 add/sub (`alt_bit`), 001 sll, 010 slt signed, 011 sltu, 100 xor, 101 srl/sra (`alt_bit`), 110 or, 111 and. Shift amount `b[$clog2(XLEN)-1:0]`. `branch_taken`=0.
- Branch accept: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu; 010/011 give 0. `result`=0; go DONE.
- Mul/div accept: latch operand magnitudes and result sign, load counter `XLEN/BITS_PER_CYCLE`; funct3 000-011 -> MUL, 100-111 -> DIV.
- funct3 000 mul (low word), 001 mulh (s×s), 010 mulhsu (s×u), 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- MUL: shift-add, `BITS_PER_CYCLE` multiplier bits per cycle into 2·XLEN accumulator. DIV: restoring division, `BITS_PER_CYCLE` quotient bits per cycle. Counter decrements each cycle; at 1 -> FIX.
- FIX: two's-complement correction (product sign = sign(a) xor sign(b) for signed forms; quotient same; remainder takes sign of dividend), select high/low word or quotient/remainder; -> DONE.
- Special cases bypass iteration, accept -> DONE directly: divisor 0 -> quotient all-ones, remainder = `a`; signed overflow (a = most-negative, b = -1) -> quotient = `a`, remainder 0.
- DONE: `out_valid`=1; `result`/`branch_taken` stable until `out_ready`. Handshake -> IDLE, or reload directly if a new accept occurs the same cycle.
- `flush`: next state IDLE, `out_valid` drops, partial results discarded; takes priority over accept and completion.

## Timing
- Reset (rst_n low at edge): state IDLE, `out_valid`=0, `result`=0, `branch_taken`=0, `busy`=0; `in_ready`=0 while `rst_n` low. Reset mid-operation aborts identically to flush.
- ALU/branch/special-case: accept at edge N -> `out_valid` high after edge N+1... i.e. visible in cycle N+1.
- Mul/div: `out_valid` visible `XLEN/BITS_PER_CYCLE + 2` cycles after accept (34 for defaults).
- Back-to-back ALU ops with `out_ready` held high: one result per cycle.
- `out_ready` low in DONE: stall indefinitely, outputs unchanged, `in_ready`=0.
- Inputs `a`, `b`, `funct3` sampled only at accept; may change during iteration.

## Structure
- Package `alu_pkg`: `func_sel` encodings, ALU/branch/M funct3 localparams, state enum type.
- Sub-module `muldiv_iter`: iterative datapath (accumulator, remainder, counter) with start/done; FSM, ALU, comparator, sign fix-up stay in `alu_muldiv`.

## Test plan
- ALU: a=0xFFFF_FFF0, b=4, sra -> 0xFFFF_FFFF; srl -> 0x0FFF_FFFF; sub of 5-7 -> 0xFFFF_FFFE; one cycle latency, back-to-back with `out_ready`=1.
- Branch: a=0xFFFF_FFFF, b=1: blt -> taken 1, bltu -> 0, bgeu -> 1, funct3 010 -> 0.
- Mul: a=-3, b=7 mul -> 0xFFFF_FFEB, mulh -> 0xFFFF_FFFF, mulhu -> 0x0000_0006; `out_valid` exactly 34 cycles after accept.
- Div: a=-7, b=2: div -> 0xFFFF_FFFD, rem -> 0xFFFF_FFFF; divu by 0 -> 0xFFFF_FFFF; div 0x8000_0000 by -1 -> 0x8000_0000, rem 0, both in 1 cycle.
- Backpressure: hold `out_ready`=0 in DONE for 10 cycles -> result stable, `in_ready`=0; release -> single handshake.
- Flush/reset at iteration 10 of a div -> IDLE next cycle, no `out_valid`; following ALU op correct; repeat all with `BITS_PER_CYCLE`=4 (latency 10).
